// File: rtl/alu_tx_pkg.sv
// Shared types and sizing helpers for the ALU result to UART TX path.
package alu_tx_pkg;

    localparam int OUT_WIDTH_DEF  = 16;
    localparam int BYTE_WIDTH_DEF = 8;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_SEND      = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_WAIT_DONE = 3'd4
    } state_e;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int num_bytes(input int out_w, input int byte_w);
        return out_w / byte_w;
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO holding captured ALU results; head visible combinationally.
// A write while full is accepted only when a read happens in the same cycle.
module result_fifo
    import alu_tx_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF,
    parameter int WIDTH = OUT_WIDTH_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_dat_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_dat_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             wr_ok, rd_ok;

    assign empty_o  = (count_q == '0);
    assign full_o   = (count_q == CNT_W'(DEPTH));
    assign rd_ok    = rd_en_i && !empty_o;
    assign wr_ok    = wr_en_i && (!full_o || rd_ok);
    assign rd_dat_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= wr_dat_i;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/alu_result_tx_ctrl.sv
// Buffers ALU results and serialises them LSB-first as bytes to the UART TX over a
// valid/busy handshake; flags results dropped when the buffer is full.
module alu_result_tx_ctrl
    import alu_tx_pkg::*;
#(
    parameter int OUT_WIDTH  = OUT_WIDTH_DEF,
    parameter int BYTE_WIDTH = BYTE_WIDTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [OUT_WIDTH-1:0]  alu_out_i,
    input  logic                  out_valid_i,
    input  logic                  tx_busy_i,
    output logic [BYTE_WIDTH-1:0] tx_p_data_o,
    output logic                  tx_d_vld_o,
    output logic                  buf_empty_o,
    output logic                  overflow_o
);

    localparam int NUM_BYTES = num_bytes(OUT_WIDTH, BYTE_WIDTH);
    localparam int CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    state_e                state_q, state_d;
    logic [OUT_WIDTH-1:0]  hold_q, hold_d;
    logic [CNT_W-1:0]      byte_cnt_q, byte_cnt_d;
    logic [BYTE_WIDTH-1:0] tx_dat_q, tx_dat_d;
    logic                  tx_vld_q, tx_vld_d;
    logic                  ovf_q, ovf_d;

    logic                  fifo_wr, fifo_rd, fifo_full, fifo_empty;
    logic [OUT_WIDTH-1:0]  fifo_rd_dat;
    logic                  last_byte;

    assign fifo_rd   = (state_q == ST_IDLE) && !fifo_empty;
    assign fifo_wr   = out_valid_i && (!fifo_full || fifo_rd);
    assign last_byte = (byte_cnt_q == CNT_W'(NUM_BYTES - 1));

    result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (OUT_WIDTH)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .wr_en_i  (fifo_wr),
        .wr_dat_i (alu_out_i),
        .rd_en_i  (fifo_rd),
        .rd_dat_o (fifo_rd_dat),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (!fifo_empty) state_d = ST_LOAD;
            ST_LOAD:      state_d = ST_SEND;
            ST_SEND:      if (!tx_busy_i) state_d = ST_WAIT_ACK;
            ST_WAIT_ACK:  if (tx_busy_i) state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: if (!tx_busy_i) state_d = last_byte ? ST_IDLE : ST_LOAD;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        hold_d     = hold_q;
        byte_cnt_d = byte_cnt_q;
        tx_dat_d   = tx_dat_q;
        tx_vld_d   = 1'b0;
        ovf_d      = ovf_q | (out_valid_i && !fifo_wr);
        case (state_q)
            ST_IDLE: begin
                if (fifo_rd) begin
                    hold_d     = fifo_rd_dat;
                    byte_cnt_d = '0;
                end
            end
            ST_LOAD:      tx_dat_d = hold_q[byte_cnt_q*BYTE_WIDTH +: BYTE_WIDTH];
            ST_SEND:      tx_vld_d = !tx_busy_i;
            ST_WAIT_DONE: if (!tx_busy_i && !last_byte) byte_cnt_d = byte_cnt_q + 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_q     <= '0;
            byte_cnt_q <= '0;
            tx_dat_q   <= '0;
            tx_vld_q   <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            byte_cnt_q <= byte_cnt_d;
            tx_dat_q   <= tx_dat_d;
            tx_vld_q   <= tx_vld_d;
            ovf_q      <= ovf_d;
        end
    end

    assign tx_p_data_o = tx_dat_q;
    assign tx_d_vld_o  = tx_vld_q;
    assign overflow_o  = ovf_q;
    assign buf_empty_o = fifo_empty && (state_q == ST_IDLE);

endmodule

// File: tb/tb_alu_result_tx_ctrl.sv
// Scoreboard bench: stimulus pushes expected bytes, a negedge monitor checks each TX strobe.
module tb_alu_result_tx_ctrl;

    logic        clk_i;
    logic        rst_i;
    logic [15:0] alu_out_i;
    logic        out_valid_i;
    logic        tx_busy_i;
    logic [7:0]  tx_p_data_o;
    logic        tx_d_vld_o;
    logic        buf_empty_o;
    logic        overflow_o;

    logic        model_busy;
    logic        man_busy;
    logic        model_en;
    int          busy_len;

    int          checks;
    int          errors;
    logic [7:0]  exp_q [$];

    assign tx_busy_i = model_busy | man_busy;

    alu_result_tx_ctrl dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .alu_out_i   (alu_out_i),
        .out_valid_i (out_valid_i),
        .tx_busy_i   (tx_busy_i),
        .tx_p_data_o (tx_p_data_o),
        .tx_d_vld_o  (tx_d_vld_o),
        .buf_empty_o (buf_empty_o),
        .overflow_o  (overflow_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic push_exp(input logic [15:0] v);
        exp_q.push_back(v[7:0]);
        exp_q.push_back(v[15:8]);
    endtask

    // UART TX model: goes busy when it sees the strobe, stays busy for busy_len cycles.
    initial begin
        model_busy = 1'b0;
        forever begin
            @(negedge clk_i);
            if (model_en && tx_d_vld_o) begin
                model_busy = 1'b1;
                repeat (busy_len) @(negedge clk_i);
                model_busy = 1'b0;
            end
        end
    end

    initial begin
        logic       prev_vld;
        logic [7:0] e;
        prev_vld = 1'b0;
        forever begin
            @(negedge clk_i);
            if (tx_d_vld_o) begin
                if (prev_vld) check("strobe_width", 32'd2, 32'd1);
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", {24'd0, tx_p_data_o}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_byte", {24'd0, tx_p_data_o}, {24'd0, e});
                end
            end
            prev_vld = tx_d_vld_o;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_i       = 1'b1;
        out_valid_i = 1'b0;
        alu_out_i   = '0;
        man_busy    = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && buf_empty_o && !tx_busy_i) && n < 2000) begin
            @(negedge clk_i);
            n++;
        end
        check(nm, (n < 2000) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic tx_ack_manual();
        int n;
        n = 0;
        while (!tx_d_vld_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        check("manual_strobe_seen", (n < 200) ? 32'd1 : 32'd0, 32'd1);
        man_busy = 1'b1;
        @(negedge clk_i);
        man_busy = 1'b0;
    endtask

    initial begin
        logic [15:0] wrap_tab [12];
        int          vld_seen;
        wrap_tab = '{16'h1101, 16'h2202, 16'h3303, 16'h4404, 16'h5505, 16'h6606,
                     16'h7707, 16'h8808, 16'h9909, 16'hAA0A, 16'hBB0B, 16'hCC0C};
        checks = 0;
        errors = 0;
        model_en = 1'b0;
        busy_len = 10;
        man_busy = 1'b0;
        @(negedge clk_i);
        do_reset();
        check("rst_vld",       {31'd0, tx_d_vld_o},  32'd0);
        check("rst_data",      {24'd0, tx_p_data_o}, 32'd0);
        check("rst_buf_empty", {31'd0, buf_empty_o}, 32'd1);
        check("rst_overflow",  {31'd0, overflow_o},  32'd0);

        // Single result, latency to first strobe.
        model_en = 1'b1;
        busy_len = 10;
        push_exp(16'hA55A);
        alu_out_i = 16'hA55A; out_valid_i = 1'b1;
        @(negedge clk_i);
        out_valid_i = 1'b0;
        check("t1_buf_empty_busy", {31'd0, buf_empty_o}, 32'd0);
        repeat (2) @(negedge clk_i);
        check("t1_no_early_vld", {31'd0, tx_d_vld_o}, 32'd0);
        @(negedge clk_i);
        check("t1_latency_vld", {31'd0, tx_d_vld_o}, 32'd1);
        wait_drain("t1_drain");
        check("t1_overflow", {31'd0, overflow_o}, 32'd0);

        // Six back-to-back results; the sixth is dropped.
        for (int i = 1; i <= 6; i++) begin
            alu_out_i   = 16'(i);
            out_valid_i = 1'b1;
            if (i <= 5) push_exp(16'(i));
            @(negedge clk_i);
        end
        out_valid_i = 1'b0;
        check("t2_overflow_set", {31'd0, overflow_o}, 32'd1);
        wait_drain("t2_drain");
        check("t2_overflow_sticky", {31'd0, overflow_o}, 32'd1);

        // Busy held high on entry to SEND.
        do_reset();
        check("t3_overflow_cleared", {31'd0, overflow_o}, 32'd0);
        man_busy = 1'b1;
        push_exp(16'h1234);
        alu_out_i = 16'h1234; out_valid_i = 1'b1;
        @(negedge clk_i);
        out_valid_i = 1'b0;
        vld_seen = 0;
        repeat (12) begin
            @(negedge clk_i);
            if (tx_d_vld_o) vld_seen++;
        end
        check("t3_no_strobe_while_busy", 32'(vld_seen), 32'd0);
        man_busy = 1'b0;
        wait_drain("t3_drain");

        // Full FIFO written on the same cycle IDLE pops.
        do_reset();
        model_en = 1'b0;
        man_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            alu_out_i   = 16'hF000 + 16'(i * 16'h0111);
            out_valid_i = 1'b1;
            push_exp(alu_out_i);
            @(negedge clk_i);
        end
        out_valid_i = 1'b0;
        man_busy = 1'b0;
        tx_ack_manual();
        tx_ack_manual();
        @(negedge clk_i);
        alu_out_i = 16'h0DD0; out_valid_i = 1'b1;
        push_exp(16'h0DD0);
        @(negedge clk_i);
        out_valid_i = 1'b0;
        check("t4_no_overflow_on_pop", {31'd0, overflow_o}, 32'd0);
        busy_len = 4;
        model_en = 1'b1;
        wait_drain("t4_drain");
        check("t4_overflow_final", {31'd0, overflow_o}, 32'd0);

        // Reset during WAIT_DONE of the first byte: MSB must never go out.
        busy_len = 10;
        exp_q.push_back(8'hEF);
        alu_out_i = 16'hBEEF; out_valid_i = 1'b1;
        @(negedge clk_i);
        out_valid_i = 1'b0;
        begin
            int n;
            n = 0;
            while (exp_q.size() != 0 && n < 100) begin
                @(negedge clk_i);
                n++;
            end
            check("t5_first_byte_sent", (n < 100) ? 32'd1 : 32'd0, 32'd1);
        end
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("t5_rst_vld",       {31'd0, tx_d_vld_o},  32'd0);
        check("t5_rst_data",      {24'd0, tx_p_data_o}, 32'd0);
        check("t5_rst_buf_empty", {31'd0, buf_empty_o}, 32'd1);
        check("t5_rst_overflow",  {31'd0, overflow_o},  32'd0);
        rst_i = 1'b0;
        repeat (40) @(negedge clk_i);
        check("t5_idle_after_rst", {31'd0, buf_empty_o}, 32'd1);

        // Pointer wrap: twelve results with gaps, all bytes in order.
        busy_len = 3;
        for (int i = 0; i < 12; i++) begin
            alu_out_i   = wrap_tab[i];
            out_valid_i = 1'b1;
            push_exp(wrap_tab[i]);
            @(negedge clk_i);
            out_valid_i = 1'b0;
            repeat (8) @(negedge clk_i);
        end
        wait_drain("t6_drain");
        check("t6_overflow", {31'd0, overflow_o}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
